conv3x3_engine: RTL and testbench

- Downstream compute stage of the line-buffer SRAM block. It consumes one 3-pixel column per transfer (`line1`/`line2`/`line3` = top/middle/bottom image rows) and keeps a sliding 3x3 window.
- It convolves the window with a 9-tap coefficient set loaded over the filter write path, through a 3-stage pipelined MAC.
- It returns `result` with a `wb_en` write-back strobe per output pixel, and requests columns from the line buffer with `shift_en`.

---
 rtl/conv3x3_engine_if.sv | 30 +++
 rtl/conv3x3_engine.sv | 143 ++++++++++++++
 tb/tb_conv3x3_engine.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_engine_if.sv
// rtl/conv3x3_engine_if.sv - filter load, column stream and result bus of the 3x3 convolution engine
interface conv3x3_engine_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 21
);
  logic              filter_valid;
  logic [COEF_W-1:0] filter_in;
  logic              start;
  logic              col_valid;
  logic [DATA_W-1:0] line1;
  logic [DATA_W-1:0] line2;
  logic [DATA_W-1:0] line3;
  logic              shift_en;
  logic [ACC_W-1:0]  result;
  logic              wb_en;
  logic              row_done;
  logic              busy;
  logic              coef_ready;

  modport master (
    output filter_valid, filter_in, start, col_valid, line1, line2, line3,
    input  shift_en, result, wb_en, row_done, busy, coef_ready
  );

  modport slave (
    input  filter_valid, filter_in, start, col_valid, line1, line2, line3,
    output shift_en, result, wb_en, row_done, busy, coef_ready
  );
endinterface

// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - sliding 3x3 window over a column stream, convolved through a 3-stage MAC
module conv3x3_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 32,
  parameter int ACC_W  = 21
) (
  input  logic             clk,
  input  logic             rst,
  conv3x3_engine_if.slave  bus
);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = PW + 2;
  localparam int CW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             col_cnt_q, col_cnt_d;
  logic signed [COEF_W-1:0]  k_q [9];
  logic [3:0]                idx_q;
  logic                      coef_ready_q;
  logic [DATA_W-1:0]         w_q [3][3];
  logic [DATA_W-1:0]         nw [3][3];
  logic signed [PW-1:0]      p_q [3][3];
  logic signed [SW-1:0]      rs_q [3];
  logic signed [ACC_W-1:0]   result_q;
  logic                      v1_q, v2_q, v3_q;
  logic                      xfer, issue, load, row_done_c;

  assign bus.shift_en   = (state_q == FILL) || (state_q == RUN);
  assign xfer           = bus.shift_en && bus.col_valid;
  assign issue          = xfer && ((state_q == RUN) || (col_cnt_q == CW'(2)));
  assign load           = (state_q == IDLE) && bus.filter_valid;
  assign bus.result     = result_q;
  assign bus.wb_en      = v3_q;
  assign bus.row_done   = row_done_c;
  assign bus.busy       = (state_q != IDLE);
  assign bus.coef_ready = coef_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    row_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && coef_ready_q) begin
          state_d   = FILL;
          col_cnt_d = '0;
        end
      end
      FILL: begin
        if (xfer) begin
          col_cnt_d = col_cnt_q + CW'(1);
          if (col_cnt_q == CW'(2)) state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          col_cnt_d = col_cnt_q + CW'(1);
          if (col_cnt_q == CW'(IMG_W - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!v1_q && !v2_q && !v3_q) begin
          row_done_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) k_q[i] <= '0;
      idx_q        <= '0;
      coef_ready_q <= 1'b0;
    end else if (load) begin
      k_q[idx_q] <= bus.filter_in;
      idx_q      <= (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
      if (idx_q == 4'd8) coef_ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) w_q[c][r] <= '0;
    end else if (xfer) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) w_q[c][r] <= nw[c][r];
    end
  end

  // Window as it will look after this edge's shift; the issuing transfer feeds S1 directly.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[0][r] = w_q[1][r];
      nw[1][r] = w_q[2][r];
    end
    nw[2][0] = bus.line1;
    nw[2][1] = bus.line2;
    nw[2][2] = bus.line3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) p_q[r][c] <= '0;
        rs_q[r] <= '0;
      end
      result_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
    end else begin
      v1_q <= issue;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (issue) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            p_q[r][c] <= PW'($signed({1'b0, nw[c][r]})) * PW'(k_q[3*r+c]);
      end
      if (v1_q) begin
        for (int r = 0; r < 3; r++)
          rs_q[r] <= SW'(p_q[r][0]) + SW'(p_q[r][1]) + SW'(p_q[r][2]);
      end
      if (v2_q) result_q <= ACC_W'(rs_q[0]) + ACC_W'(rs_q[1]) + ACC_W'(rs_q[2]);
    end
  end
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - self-checking bench for conv3x3_engine
module tb_conv3x3_engine;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int IMG_W  = 6;
  localparam int ACC_W  = 21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_engine_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) bus();

  conv3x3_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int     kind;
    int     pv;
    longint exp;
  } vec_t;

  int     total = 0;
  int     bad = 0;
  int     ref_k [9];
  int     pix [3][IMG_W];
  longint got_q [$];
  longint s1_exp [4];

  int n_xfer, t3, t_first, t_last, t_done;
  bit sh_after;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_out(input int j);
    longint s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += longint'(ref_k[3*r+c]) * longint'(pix[r][j+c]);
    return s;
  endfunction

  function automatic longint res_now();
    return longint'($signed(bus.result));
  endfunction

  task automatic set_k(input int kind);
    for (int i = 0; i < 9; i++) begin
      case (kind)
        0: ref_k[i] = (i == 4) ? 1 : 0;
        1: ref_k[i] = 1;
        2: ref_k[i] = -128;
        3: ref_k[i] = -1;
        4: ref_k[i] = i;
        default: ref_k[i] = 127;
      endcase
    end
  endtask

  task automatic set_row1_pix();
    for (int c = 0; c < IMG_W; c++) begin
      pix[0][c] = 0;
      pix[1][c] = 10 * (c + 1);
      pix[2][c] = 0;
    end
  endtask

  task automatic load_k(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      @(posedge clk); #1;
      bus.filter_valid = 1'b1;
      bus.filter_in    = COEF_W'(ref_k[i]);
    end
    @(posedge clk); #1;
    bus.filter_valid = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_shift_en"}, bus.shift_en, 0);
    chk({name, "_wb_en"}, bus.wb_en, 0);
    chk({name, "_row_done"}, bus.row_done, 0);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_coef_ready"}, bus.coef_ready, 0);
    chk({name, "_result"}, res_now(), 0);
  endtask

  // mode: 0 continuous, 1 valid every third cycle, 2 random valid
  task automatic run_row(input int mode, input int abort_at, input bit garbage);
    int  idx = 0;
    int  n = 0;
    int  t_lastx = -1;
    int  ci;
    bit  done = 0;
    got_q.delete();
    t3 = -1; t_first = -1; t_last = -1; t_done = -1; sh_after = 1'b1;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      bus.start = (n == 0);
      ci = (idx < IMG_W) ? idx : IMG_W - 1;
      if (idx >= IMG_W)   bus.col_valid = 1'b0;
      else if (mode == 0) bus.col_valid = 1'b1;
      else if (mode == 1) bus.col_valid = (n % 3 == 1);
      else                bus.col_valid = 1'($urandom_range(0, 1));
      bus.line1 = DATA_W'(pix[0][ci]);
      bus.line2 = DATA_W'(pix[1][ci]);
      bus.line3 = DATA_W'(pix[2][ci]);
      bus.filter_valid = garbage && (n >= 1);
      bus.filter_in    = COEF_W'($urandom);
      @(negedge clk);
      if (bus.wb_en) begin
        got_q.push_back(res_now());
        if (t_first < 0) t_first = n;
        t_last = n;
      end
      if (bus.row_done) begin
        t_done = n;
        done = 1;
      end
      if (idx == IMG_W && n == t_lastx + 1) sh_after = bus.shift_en;
      if (bus.shift_en && bus.col_valid) begin
        idx++;
        if (idx == 3) t3 = n;
        if (idx == IMG_W) t_lastx = n;
        if (abort_at > 0 && idx == abort_at) begin
          @(posedge clk); #1;
          rst = 1'b1;
          bus.col_valid = 1'b0;
          #1;
          chk_zero("abort");
          done = 1;
        end
      end
      n++;
    end
    bus.start = 1'b0;
    bus.col_valid = 1'b0;
    bus.filter_valid = 1'b0;
    n_xfer = idx;
    chk("row_terminated", done, 1);
  endtask

  task automatic check_row(input string name, input bit use_s1);
    chk({name, "_n_xfer"}, n_xfer, IMG_W);
    chk({name, "_n_out"}, got_q.size(), IMG_W - 2);
    chk({name, "_latency"}, t_first, t3 + 3);
    chk({name, "_row_done_at"}, t_done, t_last + 1);
    chk({name, "_shift_low_after"}, sh_after, 0);
    for (int j = 0; j < IMG_W - 2 && j < got_q.size(); j++)
      chk($sformatf("%s_res%0d", name, j), got_q[j], use_s1 ? s1_exp[j] : model_out(j));
  endtask

  initial begin
    vec_t vecs [6];
    vecs[0] = '{1, 255, 2295};
    vecs[1] = '{2, 255, -293760};
    vecs[2] = '{0, 77, 77};
    vecs[3] = '{3, 100, -900};
    vecs[4] = '{4, 2, 72};
    vecs[5] = '{5, 255, 291465};
    s1_exp[0] = 20; s1_exp[1] = 30; s1_exp[2] = 40; s1_exp[3] = 50;

    rst = 1'b1;
    bus.filter_valid = 1'b0; bus.filter_in = '0; bus.start = 1'b0; bus.col_valid = 1'b0;
    bus.line1 = '0; bus.line2 = '0; bus.line3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // start with only five taps loaded must not begin a row
    set_k(0);
    set_row1_pix();
    load_k(0, 5);
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("partial_busy", bus.busy, 0);
      chk("partial_shift_en", bus.shift_en, 0);
    end
    chk("partial_coef_ready", bus.coef_ready, 0);
    load_k(5, 4);
    @(negedge clk);
    chk("coef_ready_set", bus.coef_ready, 1);

    run_row(0, 0, 0);
    check_row("identity", 1);
    chk("result_hold", res_now(), 50);

    run_row(1, 0, 0);
    check_row("bubbles", 1);

    foreach (vecs[v]) begin
      set_k(vecs[v].kind);
      load_k(0, 9);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < IMG_W; c++) pix[r][c] = vecs[v].pv;
      run_row(0, 0, 0);
      chk($sformatf("vec%0d_n_out", v), got_q.size(), IMG_W - 2);
      foreach (got_q[j]) chk($sformatf("vec%0d_res%0d", v, j), got_q[j], vecs[v].exp);
    end

    // start in the same cycle as the k8 write is ignored
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    set_k(0);
    load_k(0, 8);
    @(posedge clk); #1;
    bus.filter_valid = 1'b1; bus.filter_in = COEF_W'(ref_k[8]); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.filter_valid = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("k8_start_busy", bus.busy, 0);
    chk("k8_start_coef_ready", bus.coef_ready, 1);

    // reset mid-row, then garbage filter writes while busy
    set_row1_pix();
    run_row(0, 4, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_busy", bus.busy, 0);
      chk("post_reset_wb_en", bus.wb_en, 0);
    end
    set_k(0);
    load_k(0, 9);
    run_row(0, 0, 1);
    check_row("garbage", 1);
    run_row(0, 0, 0);
    check_row("garbage_after", 1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 9; i++) ref_k[i] = int'($urandom_range(0, 255)) - 128;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < IMG_W; c++) pix[r][c] = int'($urandom_range(0, 255));
      load_k(0, 9);
      run_row(2, 0, 0);
      check_row($sformatf("rand%0d", t), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
